pwm_capture_reg: RTL and testbench

//  Read-side counterpart of the PWM register/generator path: measures an external PWM or

---
 rtl/pwm_capture_reg_pkg.sv | 26 ++
 rtl/pwm_capture_reg_if.sv | 12 +
 rtl/pwm_capture_reg_tick_gen.sv | 20 ++
 rtl/pwm_capture_reg.sv | 153 +++++++++++++++
 tb/tb_pwm_capture_reg.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_reg_pkg.sv
// Shared constants and types for the PWM/tach capture register block.
package pwm_capture_reg_pkg;

  localparam int unsigned DEF_CLK_DIV = 1000;
  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned RD_W        = 16;

  localparam logic [ADDR_W-1:0] ADDR_HIGH_LO = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_HIGH_HI = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PER_LO  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PER_HI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

  // Readable view of one capture, frozen by an HIGH_LO read.
  typedef struct packed {
    logic [RD_W-1:0] period;
    logic [RD_W-1:0] high;
  } cap_snap_t;

endpackage

// File: rtl/pwm_capture_reg_if.sv
// MCU read bus into the capture registers: chip select, read strobe, address, data.
interface pwm_capture_reg_if;
  import pwm_capture_reg_pkg::*;

  logic              i_cs;
  logic              i_rd;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] o_rd_data;

  modport master (output i_cs, i_rd, i_addr, input o_rd_data);
  modport slave  (input i_cs, i_rd, i_addr, output o_rd_data);
endinterface

// File: rtl/pwm_capture_reg_tick_gen.sv
// Free-running divider producing a one-sysclk measurement tick every CLK_DIV cycles.
module cap_tick_gen #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end
endmodule

// File: rtl/pwm_capture_reg.sv
// Measures high time and period of an external PWM/tach pin in ticks and
// serves the results as byte registers with an atomic snapshot on HIGH_LO reads.
module pwm_capture_reg
  import pwm_capture_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'hFFFF
) (
  input  logic               sysclk,
  input  logic               i_rst,
  input  logic               i_pwm_in,
  pwm_capture_reg_if.slave   bus,
  output logic               o_valid,
  output logic               o_timeout
);
  localparam int unsigned     IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync1_q, sync2_q, prev_q;
  logic rise_c, fall_c, edge_c, tick_c;

  cap_state_e state_q, state_d;

  logic [CNT_W-1:0]  hi_cnt_q, per_cnt_q, high_res_q, period_res_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              valid_q, timeout_q;
  cap_snap_t         snap_q;
  logic [DATA_W-1:0] rd_data_q;

  logic tmo_hit_c, start_c, capture_c, count_c, count_hi_c, tmo_clr_c;

  cap_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (sysclk),
    .rst    (i_rst),
    .tick_c (tick_c)
  );

  // Two-flop synchronizer plus one flop of history for edge detection.
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~prev_q;
  assign fall_c = ~sync2_q & prev_q;
  assign edge_c = rise_c | fall_c;

  // An edge in the same cycle pre-empts the timeout.
  assign tmo_hit_c = tick_c && !edge_c && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge sysclk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rise_c) state_d = ST_HIGH;
        ST_HIGH: if (fall_c) state_d = ST_LOW;
        ST_LOW:  if (rise_c) state_d = ST_HIGH;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_c    = 1'b0;
    capture_c  = 1'b0;
    count_c    = 1'b0;
    count_hi_c = 1'b0;
    tmo_clr_c  = 1'b0;
    if (rise_c && (state_q == ST_IDLE || state_q == ST_LOW)) start_c = 1'b1;
    if (rise_c && state_q == ST_LOW)                         capture_c = 1'b1;
    if (rise_c && state_q == ST_IDLE)                        tmo_clr_c = 1'b1;
    if (tick_c && !rise_c && !tmo_hit_c && state_q != ST_IDLE) begin
      count_c    = 1'b1;
      count_hi_c = (state_q == ST_HIGH);
    end
  end

  // Saturating tick counters; results latch the counts accumulated before the closing rise.
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      high_res_q   <= '0;
      period_res_q <= '0;
    end else begin
      if (start_c) begin
        hi_cnt_q  <= '0;
        per_cnt_q <= '0;
      end else if (count_c) begin
        if (per_cnt_q != CNT_MAX)               per_cnt_q <= per_cnt_q + CNT_W'(1);
        if (count_hi_c && hi_cnt_q != CNT_MAX)  hi_cnt_q  <= hi_cnt_q + CNT_W'(1);
      end
      if (capture_c) begin
        high_res_q   <= hi_cnt_q;
        period_res_q <= per_cnt_q;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      idle_cnt_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (edge_c)                                          idle_cnt_q <= '0;
      else if (tick_c && idle_cnt_q != IDLE_W'(TIMEOUT))   idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      if (tmo_hit_c)      valid_q <= 1'b0;
      else if (capture_c) valid_q <= 1'b1;
      if (tmo_hit_c)      timeout_q <= 1'b1;
      else if (tmo_clr_c) timeout_q <= 1'b0;
    end
  end

  // Read port: HIGH_LO freezes the current results, other addresses serve the frozen copy.
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      snap_q    <= '0;
      rd_data_q <= '0;
    end else if (bus.i_cs && bus.i_rd) begin
      case (bus.i_addr)
        ADDR_HIGH_LO: begin
          snap_q.high   <= RD_W'(high_res_q);
          snap_q.period <= RD_W'(period_res_q);
          rd_data_q     <= DATA_W'(high_res_q);
        end
        ADDR_HIGH_HI: rd_data_q <= snap_q.high[15:8];
        ADDR_PER_LO:  rd_data_q <= snap_q.period[7:0];
        ADDR_PER_HI:  rd_data_q <= snap_q.period[15:8];
        default:      rd_data_q <= rd_data_q;
      endcase
    end
  end

  assign bus.o_rd_data = rd_data_q;
  assign o_valid       = valid_q;
  assign o_timeout     = timeout_q;
endmodule

// File: tb/tb_pwm_capture_reg.sv
// Bench for pwm_capture_reg: tick-window reference model checked every cycle plus directed vectors.
module tb_pwm_capture_reg;
  localparam int TMO = 50;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;
  logic pwm8 = 1'b0;
  logic valid, timeout, valid8, timeout8;

  pwm_capture_reg_if bus ();
  pwm_capture_reg_if bus8 ();

  pwm_capture_reg #(.CLK_DIV(DIV), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .sysclk(clk), .i_rst(rst), .i_pwm_in(pwm), .bus(bus),
    .o_valid(valid), .o_timeout(timeout));

  pwm_capture_reg #(.CLK_DIV(DIV), .CNT_W(8), .TIMEOUT(1000)) dut8 (
    .sysclk(clk), .i_rst(rst), .i_pwm_in(pwm8), .bus(bus8),
    .o_valid(valid8), .o_timeout(timeout8));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input logic [7:0] got, input int exp, input int tol);
    n_checks++;
    if ($isunknown(got) || int'(got) < exp - tol || int'(got) > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h +/-%0d at %0t", name, got, exp, tol, $time);
    end
  endtask

  // Background PWM source: full periods while enabled, else a constant level.
  bit pwm_en = 1'b0;
  bit pwm_level = 1'b0;
  int pwm_hi = 40;
  int pwm_lo = 60;
  initial begin
    forever begin
      if (pwm_en) begin
        pwm = 1'b1;
        repeat (pwm_hi) @(negedge clk);
        pwm = 1'b0;
        repeat (pwm_lo) @(negedge clk);
      end else begin
        pwm = pwm_level;
        @(negedge clk);
      end
    end
  end

  // Reference model: a pin change seen at edge n becomes an edge event at edge n+2;
  // a result is the number of ticks falling in the window between events.
  int cyc = 0, rst_edge = 0, last_evt = 0, e1 = 0, f_evt = 0, phase = 0;
  int m_high = 0, m_per = 0, s_high = 0, s_per = 0;
  bit m_valid = 0, m_tmo = 0, h1 = 0, h2 = 0, h3 = 0;
  bit s_rst, s_pin, s_rd, rise, fall, tick;
  logic [1:0] s_addr;
  logic [7:0] m_rd = 8'h00;

  function automatic int tc(input int x);
    return (x - rst_edge) / DIV;
  endfunction

  function automatic int sat16(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  always @(posedge clk) begin
    s_rst = rst; s_pin = pwm; s_rd = bus.i_cs && bus.i_rd; s_addr = bus.i_addr;
    cyc++;
    if (s_rst) begin
      rst_edge = cyc; last_evt = cyc; phase = 0;
      m_valid = 0; m_tmo = 0; m_high = 0; m_per = 0; s_high = 0; s_per = 0;
      m_rd = 8'h00; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      rise = h2 && !h3;
      fall = !h2 && h3;
      tick = ((cyc - rst_edge) % DIV) == 0;
      if (s_rd) begin
        case (s_addr)
          2'd0: begin s_high = m_high; s_per = m_per; m_rd = 8'(m_high); end
          2'd1: m_rd = 8'(s_high >> 8);
          2'd2: m_rd = 8'(s_per);
          default: m_rd = 8'(s_per >> 8);
        endcase
      end
      if (rise || fall) last_evt = cyc;
      else if (tick && (tc(cyc) - tc(last_evt)) == TMO) begin
        m_tmo = 1; m_valid = 0; phase = 0;
      end
      if (rise) begin
        if (phase == 0) begin
          phase = 1; e1 = cyc; m_tmo = 0;
        end else if (phase == 2) begin
          m_high = sat16(tc(f_evt) - tc(e1));
          m_per  = sat16(tc(cyc - 1) - tc(e1));
          m_valid = 1; e1 = cyc; phase = 1;
        end
      end
      if (fall && phase == 1) begin
        phase = 2; f_evt = cyc;
      end
      h3 = h2; h2 = h1; h1 = s_pin;
    end
    #1;
    chk("cyc_valid", 8'(valid), 8'(m_valid));
    chk("cyc_timeout", 8'(timeout), 8'(m_tmo));
    chk("cyc_rd_data", bus.o_rd_data, m_rd);
  end

  task automatic rd_bus(input bit sel8, input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    if (sel8) begin bus8.i_cs = 1'b1; bus8.i_rd = 1'b1; bus8.i_addr = a; end
    else      begin bus.i_cs  = 1'b1; bus.i_rd  = 1'b1; bus.i_addr  = a; end
    @(negedge clk);
    bus.i_cs = 1'b0; bus.i_rd = 1'b0; bus8.i_cs = 1'b0; bus8.i_rd = 1'b0;
    v = sel8 ? bus8.o_rd_data : bus.o_rd_data;
  endtask

  task automatic wait_flag(input string name, input bit on_timeout, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((on_timeout ? timeout : valid) === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: flag still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  logic [7:0] v;

  initial begin
    bus.i_cs = 0; bus.i_rd = 0; bus.i_addr = 0;
    bus8.i_cs = 0; bus8.i_rd = 0; bus8.i_addr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_timeout", 8'(timeout), 8'h00);
    chk("rst_rd_data", bus.o_rd_data, 8'h00);

    // Reset in the middle of a high pulse discards everything.
    pwm_hi = 40; pwm_lo = 60; pwm_en = 1'b1;
    repeat (300) @(negedge clk);
    chk("pre_reset_valid", 8'(valid), 8'h01);
    for (int i = 0; i < 200 && pwm !== 1'b1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 8'(valid), 8'h00);
    chk("midrst_timeout", 8'(timeout), 8'h00);
    chk("midrst_rd_data", bus.o_rd_data, 8'h00);
    repeat (30) @(negedge clk);
    chk("no_capture_on_release", 8'(valid), 8'h00);

    // Steady 40/100 PWM: 10 and 25 ticks.
    wait_flag("valid_after_reset", 1'b0, 400);
    repeat (220) @(negedge clk);
    chk("model_high_40", 8'(m_high), 8'd10);
    rd_bus(0, 2'd0, v); chk_near("steady_high_lo", v, 10, 1);
    rd_bus(0, 2'd1, v); chk("steady_high_hi", v, 8'h00);
    rd_bus(0, 2'd2, v); chk_near("steady_per_lo", v, 25, 1);
    rd_bus(0, 2'd3, v); chk("steady_per_hi", v, 8'h00);

    // Snapshot coherency across a new capture.
    rd_bus(0, 2'd0, v); chk_near("coh_high_lo", v, 10, 1);
    pwm_hi = 20; pwm_lo = 40;
    repeat (250) @(negedge clk);
    rd_bus(0, 2'd2, v); chk_near("coh_per_lo_old", v, 25, 1);
    rd_bus(0, 2'd3, v); chk("coh_per_hi_old", v, 8'h00);
    rd_bus(0, 2'd0, v); chk_near("new_high_lo", v, 5, 1);
    rd_bus(0, 2'd1, v); chk("new_high_hi", v, 8'h00);
    rd_bus(0, 2'd2, v); chk_near("new_per_lo", v, 15, 1);
    rd_bus(0, 2'd3, v); chk("new_per_hi", v, 8'h00);

    // One-cycle read latency, and a strobe without chip select is ignored.
    @(negedge clk);
    bus.i_cs = 1'b1; bus.i_rd = 1'b1; bus.i_addr = 2'd2;
    chk("lat_before_edge", bus.o_rd_data, 8'h00);
    @(negedge clk);
    bus.i_cs = 1'b0; bus.i_rd = 1'b0;
    chk_near("lat_after_edge", bus.o_rd_data, 15, 1);
    @(negedge clk);
    bus.i_rd = 1'b1; bus.i_addr = 2'd0;
    @(negedge clk);
    bus.i_rd = 1'b0;
    chk_near("rd_without_cs", bus.o_rd_data, 15, 1);

    // Stuck-high input.
    pwm_level = 1'b1; pwm_en = 1'b0;
    wait_flag("stuck_timeout_seen", 1'b1, 500);
    chk("stuck_valid", 8'(valid), 8'h00);
    rd_bus(0, 2'd0, v); chk_near("stuck_high_lo", v, 5, 1);
    rd_bus(0, 2'd2, v); chk_near("stuck_per_lo", v, 15, 1);
    repeat (40) @(negedge clk);
    chk("stuck_timeout_held", 8'(timeout), 8'h01);
    pwm_hi = 20; pwm_lo = 40; pwm_en = 1'b1;
    repeat (70) @(negedge clk);
    chk("recover_timeout", 8'(timeout), 8'h00);
    chk("recover_valid_early", 8'(valid), 8'h00);
    repeat (70) @(negedge clk);
    chk("recover_valid", 8'(valid), 8'h01);

    // 8-bit counters saturate on a 300-tick high time.
    @(negedge clk); pwm8 = 1'b1;
    repeat (1200) @(negedge clk); pwm8 = 1'b0;
    repeat (200) @(negedge clk);  pwm8 = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat_valid", 8'(valid8), 8'h01);
    rd_bus(1, 2'd0, v); chk("sat_high_lo", v, 8'hFF);
    rd_bus(1, 2'd1, v); chk("sat_high_hi", v, 8'h00);
    rd_bus(1, 2'd2, v); chk("sat_per_lo", v, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
